// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared state encoding and ALU operation codes for alu_seq
package alu_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Requesters pair a first-byte op with a rest-of-bytes op, e.g. ADD/ADC, SUB/SBC.
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_ADC = 4'h1;
  localparam logic [3:0] ALU_SUB = 4'h2;
  localparam logic [3:0] ALU_SBC = 4'h3;
  localparam logic [3:0] ALU_AND = 4'h4;
  localparam logic [3:0] ALU_OR  = 4'h5;
  localparam logic [3:0] ALU_XOR = 4'h6;
  localparam logic [3:0] ALU_NOT = 4'h7;

endpackage

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - request, ALU and response signal bundle for alu_seq
interface alu_seq_if #(
  parameter int WIDTH = 8,
  parameter int WORDS = 2
);

  logic                     req_valid;
  logic                     req_ready;
  logic [WIDTH*WORDS-1:0]   req_lhs;
  logic [WIDTH*WORDS-1:0]   req_rhs;
  logic [3:0]               req_op_first;
  logic [3:0]               req_op_rest;

  logic [WIDTH-1:0]         alu_lhs;
  logic [WIDTH-1:0]         alu_rhs;
  logic [3:0]               alu_operation;
  logic [WIDTH-1:0]         alu_result;
  logic                     alu_zero;
  logic                     alu_acarry;
  logic                     alu_lcarry;
  logic                     alu_sign;
  logic                     alu_overflow;

  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [WIDTH*WORDS-1:0]   rsp_result;
  logic                     rsp_zero;
  logic                     rsp_carry;
  logic                     rsp_lcarry;
  logic                     rsp_sign;
  logic                     rsp_overflow;

  // Sequencer side
  modport slave (
    input  req_valid, req_lhs, req_rhs, req_op_first, req_op_rest,
    input  alu_result, alu_zero, alu_acarry, alu_lcarry, alu_sign, alu_overflow,
    input  rsp_ready,
    output req_ready, alu_lhs, alu_rhs, alu_operation,
    output rsp_valid, rsp_result, rsp_zero, rsp_carry, rsp_lcarry, rsp_sign, rsp_overflow
  );

  // Requester/ALU/consumer side
  modport master (
    output req_valid, req_lhs, req_rhs, req_op_first, req_op_rest,
    output alu_result, alu_zero, alu_acarry, alu_lcarry, alu_sign, alu_overflow,
    output rsp_ready,
    input  req_ready, alu_lhs, alu_rhs, alu_operation,
    input  rsp_valid, rsp_result, rsp_zero, rsp_carry, rsp_lcarry, rsp_sign, rsp_overflow
  );

endinterface

// File: rtl/alu_seq_flags.sv
// rtl/alu_seq_flags.sv - combines per-byte ALU flags into whole-operation flags
module alu_seq_flags (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic step_i,
  input  logic last_i,
  input  logic alu_zero_i,
  input  logic alu_acarry_i,
  input  logic alu_lcarry_i,
  input  logic alu_sign_i,
  input  logic alu_overflow_i,
  output logic zero_o,
  output logic carry_o,
  output logic lcarry_o,
  output logic sign_o,
  output logic overflow_o
);

  logic zero_q;
  logic carry_q;
  logic lcarry_q;
  logic sign_q;
  logic overflow_q;

  // Zero is the AND over every byte; carry/sign/overflow belong to the top byte only
  always_ff @(posedge clk) begin
    if (reset) begin
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      lcarry_q   <= 1'b0;
      sign_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else if (clear_i) begin
      zero_q     <= 1'b1;
      carry_q    <= 1'b0;
      lcarry_q   <= 1'b0;
      sign_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else if (step_i) begin
      zero_q <= zero_q & alu_zero_i;
      if (last_i) begin
        carry_q    <= alu_acarry_i;
        lcarry_q   <= alu_lcarry_i;
        sign_q     <= alu_sign_i;
        overflow_q <= alu_overflow_i;
      end
    end
  end

  assign zero_o     = zero_q;
  assign carry_o    = carry_q;
  assign lcarry_o   = lcarry_q;
  assign sign_o     = sign_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - drives an 8-bit ALU one byte per clock to build multi-byte operations
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int WORDS = 2
) (
  input  logic     clk,
  input  logic     reset,
  alu_seq_if.slave bus,
  output logic     busy
);

  localparam int OPW  = WIDTH * WORDS;
  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_e            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [OPW-1:0]    lhs_q, rhs_q;
  logic [3:0]        opf_q, opr_q;
  logic [OPW-1:0]    result_q;
  logic [WIDTH-1:0]  lhs_byte, rhs_byte;
  logic              accept;
  logic              in_exec;
  logic              last;

  assign accept  = (state_q == ST_IDLE) && bus.req_valid;
  assign in_exec = (state_q == ST_EXEC);
  assign last    = (idx_q == IDXW'(WORDS - 1));

  // State and byte index registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next state, index advance and all handshake/ALU drive outputs
  always_comb begin
    state_d           = state_q;
    idx_d             = idx_q;
    bus.req_ready     = 1'b0;
    bus.rsp_valid     = 1'b0;
    busy              = 1'b1;
    bus.alu_operation = bus.req_op_first;
    bus.alu_lhs       = '0;
    bus.alu_rhs       = '0;
    case (state_q)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        busy          = 1'b0;
        if (bus.req_valid) begin
          state_d = ST_EXEC;
          idx_d   = '0;
        end
      end
      ST_EXEC: begin
        bus.alu_lhs       = lhs_byte;
        bus.alu_rhs       = rhs_byte;
        bus.alu_operation = (idx_q == '0) ? opf_q : opr_q;
        if (last) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      ST_DONE: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operands and op codes are latched once so later request changes are ignored
  always_ff @(posedge clk) begin
    if (reset) begin
      lhs_q <= '0;
      rhs_q <= '0;
      opf_q <= '0;
      opr_q <= '0;
    end else if (accept) begin
      lhs_q <= bus.req_lhs;
      rhs_q <= bus.req_rhs;
      opf_q <= bus.req_op_first;
      opr_q <= bus.req_op_rest;
    end
  end

  // Select the operand byte for the current index
  always_comb begin
    lhs_byte = '0;
    rhs_byte = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (idx_q == IDXW'(i)) begin
        lhs_byte = lhs_q[i*WIDTH +: WIDTH];
        rhs_byte = rhs_q[i*WIDTH +: WIDTH];
      end
    end
  end

  // Store each ALU result byte into its slot of the assembled result
  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
    end else if (in_exec) begin
      for (int i = 0; i < WORDS; i++) begin
        if (idx_q == IDXW'(i)) begin
          result_q[i*WIDTH +: WIDTH] <= bus.alu_result;
        end
      end
    end
  end

  assign bus.rsp_result = result_q;

  alu_seq_flags u_flags (
    .clk            (clk),
    .reset          (reset),
    .clear_i        (accept),
    .step_i         (in_exec),
    .last_i         (last),
    .alu_zero_i     (bus.alu_zero),
    .alu_acarry_i   (bus.alu_acarry),
    .alu_lcarry_i   (bus.alu_lcarry),
    .alu_sign_i     (bus.alu_sign),
    .alu_overflow_i (bus.alu_overflow),
    .zero_o         (bus.rsp_zero),
    .carry_o        (bus.rsp_carry),
    .lcarry_o       (bus.rsp_lcarry),
    .sign_o         (bus.rsp_sign),
    .overflow_o     (bus.rsp_overflow)
  );

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - randomized self-checking bench for alu_seq, 16-bit and 8-bit instances
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic busy2;
  logic busy1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(8), .WORDS(2)) b2 ();
  alu_seq_if #(.WIDTH(8), .WORDS(1)) b1 ();

  alu_seq #(.WIDTH(8), .WORDS(2)) dut2 (.clk(clk), .reset(reset), .bus(b2), .busy(busy2));
  alu_seq #(.WIDTH(8), .WORDS(1)) dut1 (.clk(clk), .reset(reset), .bus(b1), .busy(busy1));

  // ---------------- byte ALU with its own registered previous carry ----------------
  typedef struct packed {
    logic [7:0] r;
    logic       z;
    logic       ac;
    logic       lc;
    logic       s;
    logic       v;
  } alu_out_t;

  function automatic alu_out_t alu_eval(input logic [3:0] op, input logic [7:0] a,
                                        input logic [7:0] b, input logic cin);
    alu_out_t   o;
    logic [8:0] t;
    logic [7:0] bb;
    logic       arith;
    bb    = b;
    arith = 1'b1;
    t     = '0;
    case (op)
      ALU_ADD: t = {1'b0, a} + {1'b0, b};
      ALU_ADC: t = {1'b0, a} + {1'b0, b} + {8'd0, cin};
      ALU_SUB: begin bb = ~b; t = {1'b0, a} + {1'b0, bb} + 9'd1; end
      ALU_SBC: begin bb = ~b; t = {1'b0, a} + {1'b0, bb} + {8'd0, cin}; end
      ALU_AND: begin arith = 1'b0; t = {1'b0, a & b}; end
      ALU_OR:  begin arith = 1'b0; t = {1'b0, a | b}; end
      ALU_XOR: begin arith = 1'b0; t = {1'b0, a ^ b}; end
      default: begin arith = 1'b0; t = {1'b0, ~a}; end
    endcase
    o.r  = t[7:0];
    o.z  = (t[7:0] == 8'd0);
    o.ac = arith & t[8];
    o.lc = a[7];
    o.s  = t[7];
    o.v  = arith & (a[7] == bb[7]) & (t[7] != a[7]);
    return o;
  endfunction

  alu_out_t a2o, a1o;
  logic     cprev2 = 1'b0;
  logic     cprev1 = 1'b0;

  always_comb a2o = alu_eval(b2.alu_operation, b2.alu_lhs, b2.alu_rhs, cprev2);
  always_comb a1o = alu_eval(b1.alu_operation, b1.alu_lhs, b1.alu_rhs, cprev1);
  always @(posedge clk) begin
    cprev2 <= a2o.ac;
    cprev1 <= a1o.ac;
  end

  assign b2.alu_result   = a2o.r;
  assign b2.alu_zero     = a2o.z;
  assign b2.alu_acarry   = a2o.ac;
  assign b2.alu_lcarry   = a2o.lc;
  assign b2.alu_sign     = a2o.s;
  assign b2.alu_overflow = a2o.v;
  assign b1.alu_result   = a1o.r;
  assign b1.alu_zero     = a1o.z;
  assign b1.alu_acarry   = a1o.ac;
  assign b1.alu_lcarry   = a1o.lc;
  assign b1.alu_sign     = a1o.s;
  assign b1.alu_overflow = a1o.v;

  // ---------------- whole-word reference model ----------------
  typedef struct {
    logic [15:0] r;
    logic        z, c, lc, s, v;
  } ref_t;

  function automatic ref_t ref_model(input int n, input logic [15:0] a, input logic [15:0] b,
                                     input logic [3:0] op_first);
    ref_t   e;
    longint la, lb, mask, full;
    logic   sa, sb, sr;
    mask = (longint'(1) << n) - 1;
    la   = longint'(a) & mask;
    lb   = longint'(b) & mask;
    sa   = ((la >> (n - 1)) & 1) != 0;
    sb   = ((lb >> (n - 1)) & 1) != 0;
    e.c  = 1'b0;
    e.v  = 1'b0;
    case (op_first)
      ALU_ADD: begin full = la + lb; e.c = ((full >> n) & 1) != 0; end
      ALU_SUB: begin full = la - lb; e.c = (la >= lb); end
      ALU_AND: full = la & lb;
      ALU_OR:  full = la | lb;
      ALU_XOR: full = la ^ lb;
      default: full = ~la;
    endcase
    full = full & mask;
    sr   = ((full >> (n - 1)) & 1) != 0;
    if (op_first == ALU_ADD) e.v = (sa == sb) && (sr != sa);
    if (op_first == ALU_SUB) e.v = (sa != sb) && (sr != sa);
    e.r  = 16'(full);
    e.z  = (full == 0);
    e.s  = sr;
    e.lc = sa;
    return e;
  endfunction

  logic [3:0] op_f [5] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR};
  logic [3:0] op_r [5] = '{ALU_ADC, ALU_SBC, ALU_AND, ALU_OR, ALU_XOR};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- 16-bit transaction, optional response backpressure ----------------
  task automatic op2(input logic [15:0] a, input logic [15:0] b, input logic [3:0] of,
                     input logic [3:0] orr, input int hold);
    ref_t e;
    int   cyc;
    e = ref_model(16, a, b, of);
    @(negedge clk);
    b2.req_valid = 1'b1; b2.req_lhs = a; b2.req_rhs = b;
    b2.req_op_first = of; b2.req_op_rest = orr; b2.rsp_ready = 1'b0;
    check("w2_req_ready", 32'(b2.req_ready), 32'd1);
    @(posedge clk); #1;
    b2.req_valid = 1'b0;
    b2.req_lhs   = 16'($urandom);
    b2.req_rhs   = 16'($urandom);
    cyc = 1;
    while (!b2.rsp_valid && cyc < 10) begin
      if (cyc <= 2) begin
        check("w2_alu_op",  32'(b2.alu_operation), 32'((cyc == 1) ? of : orr));
        check("w2_alu_lhs", 32'(b2.alu_lhs), 32'(a[(cyc-1)*8 +: 8]));
        check("w2_alu_rhs", 32'(b2.alu_rhs), 32'(b[(cyc-1)*8 +: 8]));
      end
      @(posedge clk); #1;
      cyc++;
    end
    check("w2_latency", 32'(cyc), 32'd3);
    check("w2_result", 32'(b2.rsp_result),   32'(e.r));
    check("w2_zero",   32'(b2.rsp_zero),     32'(e.z));
    check("w2_carry",  32'(b2.rsp_carry),    32'(e.c));
    check("w2_lcarry", 32'(b2.rsp_lcarry),   32'(e.lc));
    check("w2_sign",   32'(b2.rsp_sign),     32'(e.s));
    check("w2_ovf",    32'(b2.rsp_overflow), 32'(e.v));
    if (hold > 0) begin
      b2.req_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check("bp_valid",     32'(b2.rsp_valid),  32'd1);
        check("bp_result",    32'(b2.rsp_result), 32'(e.r));
        check("bp_req_ready", 32'(b2.req_ready),  32'd0);
        check("bp_busy",      32'(busy2),         32'd1);
      end
    end
    b2.rsp_ready = 1'b1;
    @(posedge clk); #1;
    b2.rsp_ready = 1'b0;
    check("rel_valid",     32'(b2.rsp_valid), 32'd0);
    check("rel_req_ready", 32'(b2.req_ready), 32'd1);
    check("rel_busy",      32'(busy2),        32'd0);
    b2.req_valid = 1'b0;
  endtask

  // ---------------- 8-bit transaction with rsp_ready held high throughout ----------------
  task automatic op1(input logic [7:0] a, input logic [7:0] b, input logic [3:0] of);
    ref_t e;
    int   cyc;
    e = ref_model(8, {8'd0, a}, {8'd0, b}, of);
    @(negedge clk);
    b1.req_valid = 1'b1; b1.req_lhs = a; b1.req_rhs = b;
    b1.req_op_first = of; b1.req_op_rest = ALU_NOT; b1.rsp_ready = 1'b1;
    @(posedge clk); #1;
    b1.req_valid = 1'b0;
    check("w1_alu_op", 32'(b1.alu_operation), 32'(of));
    cyc = 1;
    while (!b1.rsp_valid && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("w1_latency", 32'(cyc), 32'd2);
    check("w1_result", 32'(b1.rsp_result),   32'(e.r[7:0]));
    check("w1_zero",   32'(b1.rsp_zero),     32'(e.z));
    check("w1_carry",  32'(b1.rsp_carry),    32'(e.c));
    check("w1_sign",   32'(b1.rsp_sign),     32'(e.s));
    check("w1_ovf",    32'(b1.rsp_overflow), 32'(e.v));
    @(posedge clk); #1;
    check("w1_rel_valid", 32'(b1.rsp_valid), 32'd0);
    b1.rsp_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    b2.req_valid = 1'b0; b2.req_lhs = '0; b2.req_rhs = '0;
    b2.req_op_first = ALU_ADD; b2.req_op_rest = ALU_ADD; b2.rsp_ready = 1'b0;
    b1.req_valid = 1'b0; b1.req_lhs = '0; b1.req_rhs = '0;
    b1.req_op_first = ALU_ADD; b1.req_op_rest = ALU_ADD; b1.rsp_ready = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_req_ready", 32'(b2.req_ready),     32'd1);
    check("rst_rsp_valid", 32'(b2.rsp_valid),     32'd0);
    check("rst_busy",      32'(busy2),            32'd0);
    check("rst_result",    32'(b2.rsp_result),    32'd0);
    check("rst_flags",     32'({b2.rsp_zero, b2.rsp_carry, b2.rsp_lcarry, b2.rsp_sign, b2.rsp_overflow}), 32'd0);
    check("rst_alu_lhs",   32'(b2.alu_lhs),       32'd0);
    check("rst_alu_op",    32'(b2.alu_operation), 32'(ALU_ADD));

    op2(16'h12FF, 16'h0001, ALU_ADD, ALU_ADC, 0);
    op2(16'hFFFF, 16'h0001, ALU_ADD, ALU_ADC, 0);
    op2(16'h00FF, 16'h0001, ALU_ADD, ALU_ADC, 0);
    op2(16'h5A3C, 16'h1234, ALU_SUB, ALU_SBC, 5);
    op2(16'h0003, 16'h0005, ALU_SUB, ALU_SBC, 0);

    // Reset on the first EXEC cycle discards the operation
    @(negedge clk);
    b2.req_valid = 1'b1; b2.req_lhs = 16'h1234; b2.req_rhs = 16'h4321;
    b2.req_op_first = ALU_ADD; b2.req_op_rest = ALU_ADC;
    @(posedge clk); #1;
    b2.req_valid = 1'b0;
    check("rx_busy_pre", 32'(busy2), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rx_req_ready", 32'(b2.req_ready),  32'd1);
    check("rx_busy",      32'(busy2),         32'd0);
    check("rx_rsp_valid", 32'(b2.rsp_valid),  32'd0);
    check("rx_result",    32'(b2.rsp_result), 32'd0);
    repeat (3) @(posedge clk);
    #1 check("rx_stay_idle", 32'(busy2), 32'd0);

    // Reset while holding a response
    @(negedge clk);
    b2.req_valid = 1'b1; b2.req_lhs = 16'h0101; b2.req_rhs = 16'h0202;
    @(posedge clk); #1;
    b2.req_valid = 1'b0;
    k = 0;
    while (!b2.rsp_valid && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    check("rd_reached_done", 32'(b2.rsp_valid), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rd_rsp_valid", 32'(b2.rsp_valid),  32'd0);
    check("rd_result",    32'(b2.rsp_result), 32'd0);
    check("rd_req_ready", 32'(b2.req_ready),  32'd1);

    op1(8'h7F, 8'h01, ALU_ADD);
    op1(8'h80, 8'h01, ALU_SUB);

    for (int i = 0; i < 40; i++) begin
      k = int'($urandom_range(0, 4));
      op2(16'($urandom), 16'($urandom), op_f[k], op_r[k], int'($urandom_range(0, 2)));
      k = int'($urandom_range(0, 4));
      op1(8'($urandom), 8'($urandom), op_f[k]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
